// File: rtl/mbist_march_ctrl_w.sv
// mbist_march_ctrl_w
// Word-wide March C- memory BIST controller. It drives a synchronous RAM one
// operation per cycle. It runs over a solid background and, when DUAL_BG is
// set, a second checkerboard background. It also records failure diagnostics.
//
// Ports:
//   clk, rst            posedge clock, asynchronous active-high reset
//   start               run request, honoured only in IDLE or DONE
//   mem_cs/we/oe        RAM strobes (write: we=1, read: oe=1)
//   mem_addr, mem_din   RAM address and write data (din=0 on reads)
//   mem_dout            RAM read data, valid the cycle after the read
//   busy, done          run status
//   fault_flag          sticky miscompare flag for the current run
//   fail_cnt            saturating miscompare count
//   fail_addr/elem/bg   location of the first miscompare
//   fail_syn            dout XOR expected at the first miscompare
module mbist_march_ctrl_w #(
    parameter int ADDR    = 6,
    parameter int DW      = 8,
    parameter int DUAL_BG = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             mem_cs,
    output logic             mem_we,
    output logic             mem_oe,
    output logic [ADDR-1:0]  mem_addr,
    output logic [DW-1:0]    mem_din,
    input  logic [DW-1:0]    mem_dout,
    output logic             busy,
    output logic             done,
    output logic             fault_flag,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [ADDR-1:0]  fail_addr,
    output logic [2:0]       fail_elem,
    output logic             fail_bg,
    output logic [DW-1:0]    fail_syn
);

    localparam logic [ADDR-1:0] LAST_ADDR = '1;
    localparam logic [DW-1:0]   CHECKER   = {(DW/2){2'b01}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic [ADDR-1:0] addr_q;
    logic [2:0]      elem_q;
    logic            phase_q;   // 0: first op of an element, 1: second op
    logic            bg_q;

    logic            rd_vld;
    logic [DW-1:0]   rd_exp;
    logic [ADDR-1:0] rd_addr;
    logic [2:0]      rd_elem;
    logic            rd_bg;

    logic [ADDR-1:0] nxt_addr;
    logic [2:0]      nxt_elem;
    logic            nxt_phase;
    logic            nxt_bg;
    logic            is_last;
    logic            nxt_we;

    // M1..M4 are two ops per address (read then write); M0 and M5 are single ops.
    function automatic logic two_op(input logic [2:0] e);
        return (e != 3'd0) && (e != 3'd5);
    endfunction

    function automatic logic is_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic op_write(input logic [2:0] e, input logic p);
        if (e == 3'd0)
            return 1'b1;
        else if (e == 3'd5)
            return 1'b0;
        else
            return p;
    endfunction

    // Data for an op: background D for "0" ops and ~D for "1" ops.
    // M1/M3 are (r0,w1) and M2/M4 are (r1,w0).
    function automatic logic [DW-1:0] op_data(input logic [2:0] e, input logic p,
                                              input logic b);
        logic          inv;
        logic [DW-1:0] bgd;
        bgd = b ? CHECKER : '0;
        case (e)
            3'd1, 3'd3: inv = p;
            3'd2, 3'd4: inv = ~p;
            default:    inv = 1'b0;
        endcase
        return inv ? ~bgd : bgd;
    endfunction

    // Walks the sequence phase -> address -> element -> background and
    // flags the final op of the run.
    always_comb begin
        nxt_addr  = addr_q;
        nxt_elem  = elem_q;
        nxt_phase = 1'b0;
        nxt_bg    = bg_q;
        is_last   = 1'b0;
        if (two_op(elem_q) && !phase_q) begin
            nxt_phase = 1'b1;
        end else if (is_down(elem_q) ? (addr_q != '0) : (addr_q != LAST_ADDR)) begin
            nxt_addr = is_down(elem_q) ? addr_q - 1'b1 : addr_q + 1'b1;
        end else if (elem_q != 3'd5) begin
            nxt_elem = elem_q + 3'd1;
            nxt_addr = is_down(elem_q + 3'd1) ? LAST_ADDR : '0;
        end else if ((DUAL_BG != 0) && !bg_q) begin
            nxt_bg   = 1'b1;
            nxt_elem = 3'd0;
            nxt_addr = '0;
        end else begin
            is_last = 1'b1;
        end
        nxt_we = op_write(nxt_elem, nxt_phase);
    end

    // Main FSM. The RAM strobes are registered for the op presented in the
    // current cycle. A read issued in this cycle is compared one cycle later,
    // through the rd_* pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            elem_q     <= '0;
            phase_q    <= 1'b0;
            bg_q       <= 1'b0;
            rd_vld     <= 1'b0;
            rd_exp     <= '0;
            rd_addr    <= '0;
            rd_elem    <= '0;
            rd_bg      <= 1'b0;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            mem_oe     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault_flag <= 1'b0;
            fail_cnt   <= '0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_bg    <= 1'b0;
            fail_syn   <= '0;
        end else begin
            rd_vld <= 1'b0;

            if (rd_vld && (mem_dout != rd_exp)) begin
                fault_flag <= 1'b1;
                if (fail_cnt != '1)
                    fail_cnt <= fail_cnt + 1'b1;
                if (!fault_flag) begin
                    fail_addr <= rd_addr;
                    fail_elem <= rd_elem;
                    fail_bg   <= rd_bg;
                    fail_syn  <= mem_dout ^ rd_exp;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        fault_flag <= 1'b0;
                        fail_cnt   <= '0;
                        fail_addr  <= '0;
                        fail_elem  <= '0;
                        fail_bg    <= 1'b0;
                        fail_syn   <= '0;
                        addr_q     <= '0;
                        elem_q     <= '0;
                        phase_q    <= 1'b0;
                        bg_q       <= 1'b0;
                        mem_cs     <= 1'b1;
                        mem_we     <= 1'b1;
                        mem_oe     <= 1'b0;
                        mem_addr   <= '0;
                        mem_din    <= '0;
                    end
                end
                RUN: begin
                    if (mem_oe) begin
                        rd_vld  <= 1'b1;
                        rd_exp  <= op_data(elem_q, phase_q, bg_q);
                        rd_addr <= addr_q;
                        rd_elem <= elem_q;
                        rd_bg   <= bg_q;
                    end
                    if (is_last) begin
                        state    <= DRAIN;
                        mem_cs   <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_oe   <= 1'b0;
                        mem_addr <= '0;
                        mem_din  <= '0;
                    end else begin
                        addr_q   <= nxt_addr;
                        elem_q   <= nxt_elem;
                        phase_q  <= nxt_phase;
                        bg_q     <= nxt_bg;
                        mem_cs   <= 1'b1;
                        mem_we   <= nxt_we;
                        mem_oe   <= !nxt_we;
                        mem_addr <= nxt_addr;
                        mem_din  <= nxt_we ? op_data(nxt_elem, nxt_phase, nxt_bg) : '0;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
